// File: rtl/program_memory.sv
// Instruction store for the picoMIPS core: byte-serial boot loader assembling
// instruction words, plus a single-cycle-latency registered fetch port.
module program_memory #(
  parameter int unsigned INSTR_WIDTH = 24,
  parameter int unsigned ADDR_WIDTH  = 5,
  parameter int unsigned LOAD_WIDTH  = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   fetch_req,
  input  logic [ADDR_WIDTH-1:0]  fetch_addr,
  output logic                   fetch_ready,
  output logic                   instr_valid,
  output logic [INSTR_WIDTH-1:0] instr,
  input  logic                   load_start,
  input  logic                   load_valid,
  input  logic [LOAD_WIDTH-1:0]  load_data,
  output logic                   load_ready,
  output logic                   load_done
);

  localparam int unsigned BEATS = INSTR_WIDTH / LOAD_WIDTH;
  localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {EMPTY, LOAD, RUN} state_t;

  state_t                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  waddr_q, waddr_d;
  logic [BW-1:0]          beat_q, beat_d;
  logic [INSTR_WIDTH-1:0] word_q, word_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic                   instr_valid_q, instr_valid_d;
  logic                   load_done_q, load_done_d;
  logic                   beat_acc, wr_en, fetch_acc;

  logic [INSTR_WIDTH-1:0] mem [DEPTH];

  assign load_ready  = (state_q == LOAD);
  assign fetch_ready = (state_q == RUN) & ~load_start;
  assign beat_acc    = load_valid & load_ready;
  assign fetch_acc   = fetch_req & fetch_ready;

  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign load_done   = load_done_q;

  // load_start wins over a same-cycle beat; the beat is simply dropped.
  always_comb begin
    state_d     = state_q;
    waddr_d     = waddr_q;
    beat_d      = beat_q;
    word_d      = word_q;
    load_done_d = 1'b0;
    wr_en       = 1'b0;
    if (load_start) begin
      state_d = LOAD;
      waddr_d = '0;
      beat_d  = '0;
    end else if (beat_acc) begin
      word_d = (word_q << LOAD_WIDTH) | INSTR_WIDTH'(load_data);
      if (beat_q == BW'(BEATS - 1)) begin
        wr_en   = 1'b1;
        beat_d  = '0;
        waddr_d = waddr_q + 1'b1;
        if (waddr_q == '1) begin
          state_d     = RUN;
          load_done_d = 1'b1;
        end
      end else begin
        beat_d = beat_q + 1'b1;
      end
    end
  end

  always_comb begin
    instr_valid_d = fetch_acc;
    instr_d       = fetch_acc ? mem[fetch_addr] : instr_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= EMPTY;
      waddr_q       <= '0;
      beat_q        <= '0;
      word_q        <= '0;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      load_done_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      waddr_q       <= waddr_d;
      beat_q        <= beat_d;
      word_q        <= word_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      load_done_q   <= load_done_d;
    end
  end

  // Storage is deliberately outside the reset domain so images survive reset.
  always_ff @(posedge clock) begin
    if (wr_en) mem[waddr_q] <= word_d;
  end

endmodule

// File: tb/tb_program_memory.sv
// Self-checking bench for program_memory: table-driven fetch vectors plus
// scripted load/restart/reset sequences, with a queue of expected fetch words.
module tb_program_memory;

  localparam int unsigned IW = 24, AW = 5, LW = 8, DEPTH = 32, BEATS = 3;

  logic          clock = 1'b0;
  logic          reset;
  logic          fetch_req;
  logic [AW-1:0] fetch_addr;
  logic          fetch_ready, instr_valid;
  logic [IW-1:0] instr;
  logic          load_start, load_valid;
  logic [LW-1:0] load_data;
  logic          load_ready, load_done;

  program_memory #(.INSTR_WIDTH(IW), .ADDR_WIDTH(AW), .LOAD_WIDTH(LW)) dut (
    .clock(clock), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
    .instr_valid(instr_valid), .instr(instr),
    .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .load_done(load_done)
  );

  always #5 clock = ~clock;

  int            n_cmp = 0, n_err = 0;
  logic [IW-1:0] exp_mem [DEPTH];
  logic [IW-1:0] sb [$];
  logic          exp_run = 1'b0, exp_loading = 1'b0;
  logic [IW-1:0] last_instr = '0;
  int            beat_n = 0;

  typedef struct {
    logic          req;
    logic [AW-1:0] addr;
    logic          exp_valid;
    logic [IW-1:0] exp_instr;
  } vec_t;
  vec_t vecs [DEPTH+2];

  function automatic logic [IW-1:0] img(int k, int gen);
    logic [7:0] kb, g;
    kb = 8'(k);
    g  = 8'(gen);
    if (gen == 0) return {kb, 8'hA5, ~kb};
    return {kb ^ (g * 8'd37), 8'h5A ^ g, ~(kb + g)};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: combinational checks before the edge, registered checks after.
  task automatic cycle();
    logic          acc, bacc, done_exp;
    logic [IW-1:0] e;
    #1;
    acc  = fetch_req && exp_run && !load_start;
    bacc = load_valid && exp_loading && !load_start;
    chk("fetch_ready", 32'(fetch_ready), 32'(exp_run && !load_start));
    chk("load_ready", 32'(load_ready), 32'(exp_loading));
    done_exp = 1'b0;
    if (bacc) begin
      beat_n++;
      done_exp = (beat_n == DEPTH * BEATS);
    end
    @(posedge clock);
    #1;
    chk("load_done", 32'(load_done), 32'(done_exp));
    if (acc) begin
      e = (sb.size() != 0) ? sb.pop_front() : 'x;
      chk("instr_valid", 32'(instr_valid), 32'd1);
      chk("instr", 32'(instr), 32'(e));
      last_instr = e;
    end else begin
      chk("instr_valid_idle", 32'(instr_valid), 32'd0);
      chk("instr_held", 32'(instr), 32'(last_instr));
    end
    if (load_start) begin
      exp_loading = 1'b1;
      exp_run     = 1'b0;
      beat_n      = 0;
    end else if (done_exp) begin
      exp_loading = 1'b0;
      exp_run     = 1'b1;
    end
  endtask

  task automatic send_beat(logic [LW-1:0] d);
    int gap;
    gap = $urandom_range(0, 3);
    for (int g = 0; g < gap; g++) cycle();
    load_valid = 1'b1;
    load_data  = d;
    cycle();
    load_valid = 1'b0;
  endtask

  task automatic send_word(int w, logic [IW-1:0] data);
    for (int b = 0; b < BEATS; b++)
      send_beat(LW'(data >> (LW * (BEATS - 1 - b))));
    exp_mem[w] = data;
  endtask

  task automatic start_load();
    load_start = 1'b1;
    cycle();
    load_start = 1'b0;
  endtask

  task automatic load_image(int gen);
    start_load();
    for (int w = 0; w < DEPTH; w++) send_word(w, img(w, gen));
    cycle();
  endtask

  task automatic fetch_all();
    for (int k = 0; k < DEPTH; k++) begin
      fetch_req  = 1'b1;
      fetch_addr = AW'(k);
      sb.push_back(exp_mem[k]);
      cycle();
    end
    fetch_req = 1'b0;
    cycle();
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, "_instr"}, 32'(instr), 32'd0);
    chk({tag, "_instr_valid"}, 32'(instr_valid), 32'd0);
    chk({tag, "_load_done"}, 32'(load_done), 32'd0);
    chk({tag, "_load_ready"}, 32'(load_ready), 32'd0);
    chk({tag, "_fetch_ready"}, 32'(fetch_ready), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; fetch_req = 1'b0; fetch_addr = '0;
    load_start = 1'b0; load_valid = 1'b0; load_data = '0;

    for (int k = 0; k < DEPTH; k++)
      vecs[k] = '{req: 1'b1, addr: AW'(k), exp_valid: 1'b1, exp_instr: img(k, 0)};
    vecs[DEPTH]   = '{req: 1'b0, addr: AW'(0), exp_valid: 1'b0, exp_instr: '0};
    vecs[DEPTH+1] = '{req: 1'b1, addr: AW'(DEPTH-1), exp_valid: 1'b1, exp_instr: img(DEPTH-1, 0)};

    #2;
    check_reset_outputs("por");
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;

    // EMPTY: requests and stray beats are ignored.
    fetch_req = 1'b1; fetch_addr = AW'(3); load_valid = 1'b1; load_data = 8'hFF;
    repeat (10) cycle();
    fetch_req = 1'b0; load_valid = 1'b0;

    load_image(0);
    for (int i = 0; i < DEPTH + 2; i++) begin
      fetch_req  = vecs[i].req;
      fetch_addr = vecs[i].addr;
      if (vecs[i].exp_valid) sb.push_back(vecs[i].exp_instr);
      cycle();
    end
    fetch_req = 1'b0;
    cycle();

    // Restart mid-word, then again with a same-cycle beat that must be dropped.
    start_load();
    for (int w = 0; w < 5; w++) send_word(w, img(w, 1));
    send_beat(8'h11);
    send_beat(8'h22);
    load_start = 1'b1; load_valid = 1'b1; load_data = 8'hEE;
    cycle();
    load_start = 1'b0; load_valid = 1'b0;
    for (int w = 0; w < DEPTH; w++) send_word(w, img(w, 2));
    cycle();
    fetch_all();

    // Fetch in flight, then fetch and load_start together.
    fetch_req = 1'b1; fetch_addr = AW'(7);
    sb.push_back(exp_mem[7]);
    cycle();
    load_start = 1'b1;
    cycle();
    load_start = 1'b0;
    cycle();
    fetch_req = 1'b0;

    // Asynchronous reset in the middle of word 10.
    for (int w = 0; w < 10; w++) send_word(w, img(w, 3));
    send_beat(8'h33);
    #3;
    reset = 1'b1;
    #1;
    check_reset_outputs("async");
    exp_run = 1'b0; exp_loading = 1'b0; last_instr = '0; beat_n = 0;
    sb.delete();
    @(negedge clock);
    reset = 1'b0;
    fetch_req = 1'b1; fetch_addr = AW'(2);
    repeat (4) cycle();
    fetch_req = 1'b0;

    load_image(4);
    fetch_all();

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/program_memory.md
Name: program_memory

Overview:
- Instruction store and fetch responder for the picoMIPS core. It answers instruction-address requests issued by the program counter side.
- Returns a registered INSTR_WIDTH-bit instruction one cycle after an accepted request.
- Filled at boot through a byte-serial load port. A small FSM assembles LOAD_WIDTH-bit beats into instruction words.
- Gates fetches until a complete image has been loaded.

Parameters:
- INSTR_WIDTH, 24, instruction word width; must be an integer multiple of LOAD_WIDTH.
- ADDR_WIDTH, 5, fetch/write address width; depth = 2^ADDR_WIDTH words.
- LOAD_WIDTH, 8, load-port beat width; BEATS = INSTR_WIDTH/LOAD_WIDTH (default 3).

Ports:
- clock, in, 1, single system clock; all state updates on rising edge.
- reset, in, 1, asynchronous, active-high reset.
- fetch_req, in, 1, fetch request from the PC side.
- fetch_addr, in, ADDR_WIDTH, instruction address to read.
- fetch_ready, out, 1, request is accepted this cycle when fetch_req & fetch_ready.
- instr_valid, out, 1, instr holds the response to the request accepted the previous cycle.
- instr, out, INSTR_WIDTH, registered instruction word.
- load_start, in, 1, one-cycle command: begin or restart an image load at address 0.
- load_valid, in, 1, load_data beat present.
- load_data, in, LOAD_WIDTH, image beat, most-significant beat of each word first.
- load_ready, out, 1, beat is accepted when load_valid & load_ready.
- load_done, out, 1, one-cycle pulse when the last word of the image is written.

Behaviour:
- FSM states:
  - EMPTY (reset state): no valid image.
  - LOAD: image load in progress.
  - RUN: image valid, fetches served.
- Reset values (asynchronous, applied immediately):
  - state=EMPTY; waddr=0; beat count=0; assembly register=0.
  - instr=0, instr_valid=0, load_done=0.
  - Memory array contents are not reset; they are retained across reset.
- Combinational outputs:
  - load_ready = (state==LOAD).
  - fetch_ready = (state==RUN) & ~load_start.
- load_start precedence:
  - From any state, load_start moves the FSM to LOAD next cycle and clears waddr and beat count.
  - It has priority over a same-cycle beat (the beat is dropped) and over a same-cycle fetch (not accepted).
- Word assembly in LOAD:
  - Each accepted beat shifts into the assembly register MSB-first: word = {word[INSTR_WIDTH-LOAD_WIDTH-1:0], load_data}.
  - On the BEATS-th beat, the complete word (including that beat) is written to mem[waddr]; beat count returns to 0 and waddr increments.
  - load_valid while load_ready=0 is ignored; nothing is buffered.
- End of load:
  - When the word at waddr = 2^ADDR_WIDTH-1 is written, the FSM enters RUN and load_done is high for exactly the next cycle.
  - waddr wraps to 0 and is not used further.
- Fetch in RUN:
  - A request accepted at edge N produces instr=mem[fetch_addr] and instr_valid=1 after edge N+1 (latency 1).
  - Back-to-back requests give a result every cycle.
  - In a cycle with no accepted request, instr_valid=0 and instr holds its last value.
- Fetch outside RUN:
  - fetch_req in EMPTY or LOAD is never accepted; instr_valid stays 0.
  - The requester holds fetch_req/fetch_addr until fetch_ready is high.
- Restart and reset mid-operation:
  - load_start during LOAD discards the partial word and the progress made so far.
  - Words already written stay in memory until overwritten.
  - reset mid-load returns to EMPTY; a new load_start is required before fetches resume.
  - A fetch in flight when load_start arrives (accepted the previous cycle) still completes with instr_valid=1.
- Memory write and read of the same address never occur in the same cycle (states are exclusive).

Test Plan:
- Reset, then hold fetch_req=1 for 10 cycles.
  -> fetch_ready=0, instr_valid=0, instr=0 throughout; load_ready=0 in EMPTY.
- load_start, then stream 96 beats: word k = {k, 8'hA5, ~k}, gaps of 0-3 cycles between beats.
  -> load_done pulses exactly once, one cycle after the 96th beat; fetch_ready=1 from the next cycle.
- In RUN, fetch_addr 0,1,…,31 on consecutive cycles.
  -> instr matches word k one cycle after each request with instr_valid=1 continuously; idle cycle gives instr_valid=0 with instr held.
- During LOAD, send 2 beats of word 5, then assert load_start.
  -> beat count and waddr return to 0; next 3 beats land in mem[0]; the partial word is discarded.
- Assert reset asynchronously (mid-clock) at word 10 of a load.
  -> outputs reach reset values immediately; state EMPTY; after a full reload, data is correct.
- In RUN, assert fetch_req and load_start in the same cycle.
  -> no fetch is accepted (instr_valid=0 next cycle); FSM enters LOAD; the prior-cycle fetch still returns valid.
